mem_wb_skid_stage: RTL and testbench
====================================

// Module: mem_wb_skid_stage
// PURPOSE
// - Parametrised MEM->WB pipeline register with valid/ready flow control, flush and optional skid entry.
// - Decodes the write-back controls, selects the write-back data and gates register-file writes with valid.
// - Sits between the data-memory stage and the register file.
// - Lets a stalled write-back hold without losing the beat in flight.
// PARAMETERS
// - DATA_W        32  width of ALU result, memory read data and write-back data
// - RD_W          5   destination register address width
// - CTRL_W        9   width of the EX/MEM control-bit vector, ascending range [0:CTRL_W-1]
// - MEMTOREG_IDX  3   index of the MemToReg bit in the control vector
// - REGWRITE_IDX  6   index of the RegWrite bit in the control vector
// - SKID          1   1 = two-entry (main + skid), in_ready registered; 0 = single entry, in_ready combinational
// - ZERO_REG_WR   0   0 = suppress reg_write when rd==0; 1 = allow it
// PORTS
// - clock          in   1         rising-edge clock
// - reset_n        in   1         asynchronous reset, active low
// - in_valid       in   1         MEM stage presents a beat
// - in_ready       out  1         stage accepts a beat this cycle
// - in_result      in   DATA_W    ALU result
// - in_read_data   in   DATA_W    data-memory read data
// - in_rd          in   RD_W      destination register
// - in_ctrl        in   CTRL_W    EX/MEM control bits [0:CTRL_W-1]
// - flush          in   1         discard every held beat
// - out_valid      out  1         WB beat present
// - out_ready      in   1         WB consumes the beat (register-file write port free)
// - out_result     out  DATA_W    registered result
// - out_read_data  out  DATA_W    registered read data
// - out_rd         out  RD_W      registered destination register
// - out_mem_to_reg out  1         registered in_ctrl[MEMTOREG_IDX]
// - out_reg_write  out  1         registered RegWrite & out_valid & (ZERO_REG_WR | out_rd!=0)
// - out_wb_data    out  DATA_W    out_mem_to_reg ? out_read_data : out_result (combinational)
// BEHAVIOUR
// - Reset (async, reset_n=0): all valid flags, data, rd and ctrl regs = 0.
//   - Outputs are 0; in_ready=1.
// - Accept = in_valid & in_ready. Drain = out_valid & out_ready. Latency 1 cycle, input to output.
// - SKID=1:
//   - in_ready = !skid_valid, driven from a flop only.
//   - Main empty, or main draining with skid empty: an accepted beat loads main.
//   - Main full and not draining: an accepted beat loads skid. in_ready drops next cycle.
//   - Drain while skid full: skid moves to main and skid empties. Accept is impossible that cycle.
//   - Full throughput (one beat per cycle) when out_ready is held at 1.
// - SKID=0:
//   - in_ready = !out_valid | out_ready.
//   - Accept loads main. Drain without accept clears out_valid.
// - Output fields hold stable while out_valid & !out_ready.
// - Flush (synchronous, highest priority):
//   - Next edge: both valid flags = 0, so out_reg_write = 0. Data regs may keep stale values.
//   - A beat accepted in the flush cycle is dropped.
//   - in_ready = 1 the cycle after flush.
// - out_reg_write is never 1 while out_valid=0, which prevents spurious register-file writes.
// - Reset asserted mid-transfer: the beat is lost, outputs clear immediately without waiting for a clock.
// - Simultaneous accept + drain with main full and skid empty: main takes the new beat, skid stays empty.
// - Widths: all data paths are exactly DATA_W. No extension or truncation happens inside the block.
// STRUCTURE
// - Shared package (pipeline defs): CTRL_W, MEMTOREG_IDX, REGWRITE_IDX and the other control-bit index constants.
// - One sub-module: pipe_entry_reg.
//   - Holds a valid flag plus a payload of DATA_W*2 + RD_W + 1 (mem_to_reg) + 1 (reg_write).
//   - Has load and clear inputs; instantiated once for main and once for skid (generate on SKID).
// - Top-level logic: entry steering, in_ready, flush, reg_write gating, write-back mux.
// TESTING
// - Reset: drive reset_n=0 mid-cycle with out_valid=1 -> out_valid, out_reg_write, out_wb_data = 0 at once; in_ready=1.
// - Streaming: 8 back-to-back beats, out_ready=1 -> 8 consecutive beats out, each 1 cycle later; in_ready stays 1.
// - Backpressure (SKID=1): out_ready=0, send A=0x11 then B=0x22.
//   -> out holds A; in_ready=0 on the 3rd cycle.
//   -> After out_ready=1: A then B, no loss or duplication.
// - Mux/gating: ctrl[3]=1, result=0xAAAA, read_data=0x5555 -> out_wb_data=0x5555.
//   - ctrl[6]=1, rd=0, ZERO_REG_WR=0 -> out_reg_write=0. Same with rd=7 -> 1.
// - Flush: two beats held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle beat never appears.
// - SKID=0 build: out_ready toggles 1010 with continuous in_valid -> in_ready mirrors out_ready while full; order preserved.

Source files
------------

// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared pipeline definitions for the MEM->WB stage.
// Control-vector bit positions and the decoded write-back control bundle.
package mem_wb_skid_stage_pkg;

   localparam int unsigned CTRL_W       = 9;

   localparam int unsigned ALUSRC_IDX   = 0;
   localparam int unsigned ALUOP0_IDX   = 1;
   localparam int unsigned ALUOP1_IDX   = 2;
   localparam int unsigned MEMTOREG_IDX = 3;
   localparam int unsigned MEMREAD_IDX  = 4;
   localparam int unsigned MEMWRITE_IDX = 5;
   localparam int unsigned REGWRITE_IDX = 6;
   localparam int unsigned BRANCH_IDX   = 7;
   localparam int unsigned JUMP_IDX     = 8;

   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
   } wb_ctrl_t;

   localparam int unsigned WB_CTRL_W = $bits(wb_ctrl_t);

   function automatic int unsigned entry_w(
      input int unsigned data_w,
      input int unsigned rd_w
   );
      return 2 * data_w + rd_w + WB_CTRL_W;
   endfunction

endpackage

// File: rtl/mem_wb_skid_stage_pipe_entry_reg.sv
// One pipeline slot: a valid flag plus an opaque payload word.
// Clear wins over load; the payload only changes on load.
module pipe_entry_reg #(
   parameter int unsigned PAYLOAD_W = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic                 clear,
   input  logic [PAYLOAD_W-1:0] load_payload,
   output logic                 valid,
   output logic [PAYLOAD_W-1:0] payload
);

   logic                 valid_d;
   logic                 valid_q;
   logic [PAYLOAD_W-1:0] payload_d;
   logic [PAYLOAD_W-1:0] payload_q;

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (load) begin
         valid_d   = 1'b1;
         payload_d = load_payload;
      end
      if (clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign valid   = valid_q;
   assign payload = payload_q;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with valid/ready flow control,
// flush, optional skid slot and write-back data selection.
module mem_wb_skid_stage #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned RD_W         = 5,
   parameter int unsigned CTRL_W       = mem_wb_skid_stage_pkg::CTRL_W,
   parameter int unsigned MEMTOREG_IDX = mem_wb_skid_stage_pkg::MEMTOREG_IDX,
   parameter int unsigned REGWRITE_IDX = mem_wb_skid_stage_pkg::REGWRITE_IDX,
   parameter int unsigned SKID         = 1,
   parameter int unsigned ZERO_REG_WR  = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [DATA_W-1:0] in_read_data,
   input  logic [RD_W-1:0]   in_rd,
   input  logic [0:CTRL_W-1] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_read_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_mem_to_reg,
   output logic              out_reg_write,
   output logic [DATA_W-1:0] out_wb_data
);

   import mem_wb_skid_stage_pkg::*;

   localparam int unsigned PW = entry_w(DATA_W, RD_W);

   wb_ctrl_t        in_wb;
   logic            rd_ok;
   logic [PW-1:0]   in_payload;
   logic [PW-1:0]   main_payload;
   logic [PW-1:0]   skid_payload;
   logic [PW-1:0]   main_src;
   logic            main_valid;
   logic            skid_valid;
   logic            main_rw;
   logic            accept;
   logic            drain;
   logic            main_load;
   logic            main_clear;
   logic            main_sel_skid;
   logic            skid_load;
   logic            skid_clear;
   logic            ctrl_unused;

   // rd==0 writes are folded into the stored RegWrite bit at capture time
   assign rd_ok = (ZERO_REG_WR != 0) || (in_rd != '0);

   assign in_wb.mem_to_reg = in_ctrl[MEMTOREG_IDX];
   assign in_wb.reg_write  = in_ctrl[REGWRITE_IDX] & rd_ok;
   assign ctrl_unused      = ^in_ctrl;

   assign in_payload = {in_result, in_read_data, in_rd, in_wb};

   assign accept = in_valid & in_ready;
   assign drain  = main_valid & out_ready;

   always_comb begin
      main_load     = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clear    = 1'b0;
      if (SKID != 0) begin
         main_sel_skid = drain & skid_valid;
         main_load     = main_sel_skid
                       | (accept & (~main_valid | drain));
         skid_load     = accept & main_valid & ~drain;
         skid_clear    = main_sel_skid;
      end else begin
         main_load = accept;
      end
      main_clear = drain & ~main_load;
      if (flush) begin
         main_load  = 1'b0;
         skid_load  = 1'b0;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end
   end

   assign main_src = main_sel_skid ? skid_payload : in_payload;

   pipe_entry_reg #(
      .PAYLOAD_W (PW)
   ) u_main (
      .clock        (clock),
      .reset_n      (reset_n),
      .load         (main_load),
      .clear        (main_clear),
      .load_payload (main_src),
      .valid        (main_valid),
      .payload      (main_payload)
   );

   generate
      if (SKID != 0) begin : g_skid
         // in_ready comes straight from the skid flop, no comb path
         assign in_ready = ~skid_valid;

         pipe_entry_reg #(
            .PAYLOAD_W (PW)
         ) u_skid (
            .clock        (clock),
            .reset_n      (reset_n),
            .load         (skid_load),
            .clear        (skid_clear),
            .load_payload (in_payload),
            .valid        (skid_valid),
            .payload      (skid_payload)
         );
      end else begin : g_noskid
         logic skid_unused;

         assign in_ready     = ~main_valid | out_ready;
         assign skid_valid   = 1'b0;
         assign skid_payload = '0;
         assign skid_unused  = skid_load | skid_clear;
      end
   endgenerate

   assign {out_result, out_read_data, out_rd,
           out_mem_to_reg, main_rw} = main_payload;

   assign out_valid     = main_valid;
   assign out_reg_write = main_rw & main_valid;
   assign out_wb_data   = out_mem_to_reg ? out_read_data
                                         : out_result;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: SKID=1 and SKID=0 builds side by side,
// each checked against a queue model of the beats in flight.
module tb_mem_wb_skid_stage;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 9;

   typedef struct packed {
      logic [DW-1:0] res;
      logic [DW-1:0] rdat;
      logic [RW-1:0] rd;
      logic [0:CW-1] ctrl;
   } beat_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   beat_t b1, b0;
   logic iv1, or1, fl1, iv0, or0, fl0;
   logic ir1, ov1, m2r1, rw1, ir0, ov0, m2r0, rw0;
   logic [DW-1:0] res1, rdat1, wb1, res0, rdat0, wb0;
   logic [RW-1:0] rd1, rd0;

   mem_wb_skid_stage #(.SKID(1)) dut1 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(iv1), .in_ready(ir1),
      .in_result(b1.res), .in_read_data(b1.rdat),
      .in_rd(b1.rd), .in_ctrl(b1.ctrl), .flush(fl1),
      .out_valid(ov1), .out_ready(or1),
      .out_result(res1), .out_read_data(rdat1),
      .out_rd(rd1), .out_mem_to_reg(m2r1),
      .out_reg_write(rw1), .out_wb_data(wb1)
   );

   mem_wb_skid_stage #(.SKID(0)) dut0 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(iv0), .in_ready(ir0),
      .in_result(b0.res), .in_read_data(b0.rdat),
      .in_rd(b0.rd), .in_ctrl(b0.ctrl), .flush(fl0),
      .out_valid(ov0), .out_ready(or0),
      .out_result(res0), .out_read_data(rdat0),
      .out_rd(rd0), .out_mem_to_reg(m2r0),
      .out_reg_write(rw0), .out_wb_data(wb0)
   );

   beat_t q1[$];
   beat_t q0[$];
   int checks = 0;
   int failures = 0;

   function automatic beat_t rnd_beat();
      beat_t b;
      b.res  = $urandom;
      b.rdat = $urandom;
      b.rd   = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
      b.ctrl = CW'($urandom);
      return b;
   endfunction

   function automatic logic [DW-1:0] exp_wb(beat_t b);
      return b.ctrl[3] ? b.rdat : b.res;
   endfunction

   function automatic logic exp_rw(beat_t b);
      return b.ctrl[6] && (b.rd != '0);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(string s, int cnt, beat_t f, logic exp_ir,
                            logic ir, logic ov, logic [DW-1:0] res,
                            logic [DW-1:0] rdat, logic [RW-1:0] rd,
                            logic m2r, logic rw, logic [DW-1:0] wb);
      chk({s, "_in_ready"}, 32'(ir), 32'(exp_ir));
      chk({s, "_out_valid"}, 32'(ov), 32'(cnt > 0));
      chk({s, "_reg_write"}, 32'(rw), 32'(cnt > 0 && exp_rw(f)));
      if (cnt > 0) begin
         chk({s, "_result"}, res, f.res);
         chk({s, "_read_data"}, rdat, f.rdat);
         chk({s, "_rd"}, 32'(rd), 32'(f.rd));
         chk({s, "_mem_to_reg"}, 32'(m2r), 32'(f.ctrl[3]));
         chk({s, "_wb_data"}, wb, exp_wb(f));
      end
   endtask

   // One clock: check at negedge, then advance the models at posedge.
   task automatic cycle();
      logic a1, d1, a0, d0;
      beat_t f1, f0;
      @(negedge clock);
      f1 = (q1.size() > 0) ? q1[0] : '0;
      f0 = (q0.size() > 0) ? q0[0] : '0;
      check_dut("s1", q1.size(), f1, q1.size() < 2,
                ir1, ov1, res1, rdat1, rd1, m2r1, rw1, wb1);
      check_dut("s0", q0.size(), f0, q0.size() == 0 || or0,
                ir0, ov0, res0, rdat0, rd0, m2r0, rw0, wb0);
      a1 = iv1 && (q1.size() < 2);
      d1 = or1 && (q1.size() > 0);
      a0 = iv0 && (q0.size() == 0 || or0);
      d0 = or0 && (q0.size() > 0);
      @(posedge clock);
      if (fl1) q1.delete();
      else begin
         if (d1) void'(q1.pop_front());
         if (a1) q1.push_back(b1);
      end
      if (fl0) q0.delete();
      else begin
         if (d0) void'(q0.pop_front());
         if (a0) q0.push_back(b0);
      end
      #1;
   endtask

   initial begin
      {iv1, or1, fl1, iv0, or0, fl0} = '0;
      b1 = '0;
      b0 = '0;
      #2;
      chk("rst_in_ready1", 32'(ir1), 32'd1);
      chk("rst_out_valid1", 32'(ov1), 32'd0);
      chk("rst_reg_write1", 32'(rw1), 32'd0);
      chk("rst_wb_data1", wb1, 32'd0);
      chk("rst_result1", res1, 32'd0);
      chk("rst_in_ready0", 32'(ir0), 32'd1);
      @(negedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;

      // reset asserted while a beat is held
      b1 = '0;
      b1.res = 32'hDEAD_BEEF;
      b1.rd = 5'd9;
      b1.ctrl[6] = 1'b1;
      iv1 = 1'b1;
      cycle();
      iv1 = 1'b0;
      chk("pre_rst_out_valid", 32'(ov1), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(ov1), 32'd0);
      chk("async_rst_reg_write", 32'(rw1), 32'd0);
      chk("async_rst_wb_data", wb1, 32'd0);
      chk("async_rst_in_ready", 32'(ir1), 32'd1);
      q1.delete();
      q0.delete();
      @(negedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;

      // streaming, 8 back-to-back beats
      or1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b1 = rnd_beat();
         iv1 = 1'b1;
         cycle();
      end
      iv1 = 1'b0;
      cycle();
      cycle();

      // backpressure with A then B
      or1 = 1'b0;
      b1 = rnd_beat();
      b1.res = 32'h11;
      iv1 = 1'b1;
      cycle();
      b1 = rnd_beat();
      b1.res = 32'h22;
      cycle();
      iv1 = 1'b0;
      chk("bp_in_ready_low", 32'(ir1), 32'd0);
      chk("bp_hold_a", res1, 32'h11);
      cycle();
      cycle();
      or1 = 1'b1;
      cycle();
      cycle();
      cycle();

      // write-back mux and reg_write gating
      b1 = '0;
      b1.res = 32'hAAAA;
      b1.rdat = 32'h5555;
      b1.rd = 5'd7;
      b1.ctrl[3] = 1'b1;
      b1.ctrl[6] = 1'b1;
      iv1 = 1'b1;
      cycle();
      chk("mux_wb_data", wb1, 32'h5555);
      chk("rw_rd7", 32'(rw1), 32'd1);
      b1.rd = 5'd0;
      cycle();
      chk("rw_rd0", 32'(rw1), 32'd0);
      iv1 = 1'b0;
      cycle();

      // flush with two beats held and a new beat offered
      or1 = 1'b0;
      iv1 = 1'b1;
      b1 = rnd_beat();
      cycle();
      b1 = rnd_beat();
      cycle();
      b1 = rnd_beat();
      fl1 = 1'b1;
      cycle();
      fl1 = 1'b0;
      iv1 = 1'b0;
      chk("flush_out_valid", 32'(ov1), 32'd0);
      chk("flush_in_ready", 32'(ir1), 32'd1);
      or1 = 1'b1;
      cycle();
      cycle();

      // SKID=0 build with out_ready toggling 1010
      iv0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         or0 = (i % 2) == 0;
         b0 = rnd_beat();
         cycle();
      end
      iv0 = 1'b0;
      or0 = 1'b1;
      cycle();
      cycle();

      // randomized traffic on both builds
      for (int i = 0; i < 300; i++) begin
         b1  = rnd_beat();
         b0  = rnd_beat();
         iv1 = 1'($urandom_range(0, 1));
         iv0 = 1'($urandom_range(0, 1));
         or1 = $urandom_range(0, 3) != 0;
         or0 = $urandom_range(0, 3) != 0;
         fl1 = $urandom_range(0, 15) == 0;
         fl0 = $urandom_range(0, 15) == 0;
         cycle();
      end
      {iv1, fl1, iv0, fl0} = '0;
      or1 = 1'b1;
      or0 = 1'b1;
      cycle();
      cycle();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
